load_store_unit: RTL and testbench



---
 rtl/load_store_unit.sv | 174 +++++++++++++++++
 tb/tb_load_store_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed data memory; sub-word stores use read-modify-write.
// Optional macro LSU_BOUND_CHECK_EN rejects word indices >= size at accept.
module load_store_unit #(
  parameter int bits = 32,
  parameter int addr = 20,
  parameter int size = 100
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req,
  input  logic            we,
  input  logic [1:0]      width,
  input  logic            sign_ext,
  input  logic [addr+1:0] byte_addr,
  input  logic [bits-1:0] wdata,
  output logic            ready,
  output logic            done,
  output logic            err,
  output logic [bits-1:0] rdata,
  output logic [1:0]      dm_flag,
  output logic [addr-1:0] dm_address,
  output logic [bits-1:0] dm_data,
  input  logic [bits-1:0] dm_read
);

  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, DONE} state_t;

  state_t          state_reg;
  logic            ready_reg;
  logic            done_reg;
  logic            err_reg;
  logic            flag_reg;
  logic [bits-1:0] rdata_reg;
  logic [addr-1:0] addr_reg;
  logic [bits-1:0] data_reg;
  logic [1:0]      width_reg;
  logic            sign_reg;
  logic [1:0]      off_reg;
  logic [15:0]     wdata_reg;

  logic            misalign;
  logic            range_en;
  logic            out_of_range;
  logic            reject;
  logic [7:0]      rd_byte [4];
  logic [7:0]      lane_byte;
  logic [15:0]     lane_half;
  logic [bits-1:0] load_word;
  logic [bits-1:0] merged_word;

`ifdef LSU_BOUND_CHECK_EN
  assign range_en = 1'b1;
`else
  assign range_en = 1'b0;
`endif

  assign out_of_range = range_en && (32'(byte_addr[addr+1:2]) >= size);

  always_comb begin
    misalign = 1'b0;
    case (width)
      2'd1:    misalign = byte_addr[0];
      2'd2:    misalign = |byte_addr[1:0];
      2'd3:    misalign = 1'b1;
      default: misalign = 1'b0;
    endcase
  end

  assign reject = misalign || out_of_range;

  // Little-endian lanes: byte k is bits 8k+7:8k; a halfword covers lanes 2h and 2h+1.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic hit_byte;
    logic hit_half;
    assign rd_byte[gi] = dm_read[8*gi +: 8];
    assign hit_byte    = (width_reg == 2'd0) && (off_reg == 2'(gi));
    assign hit_half    = (width_reg == 2'd1) && (off_reg[1] == 1'(gi / 2));
    assign merged_word[8*gi +: 8] = hit_byte ? wdata_reg[7:0] :
                                    hit_half ? wdata_reg[8*(gi%2) +: 8] :
                                               dm_read[8*gi +: 8];
  end

  assign lane_byte = rd_byte[off_reg];
  assign lane_half = off_reg[1] ? dm_read[31:16] : dm_read[15:0];

  always_comb begin
    load_word = dm_read;
    case (width_reg)
      2'd0:    load_word = {{24{sign_reg & lane_byte[7]}}, lane_byte};
      2'd1:    load_word = {{16{sign_reg & lane_half[15]}}, lane_half};
      default: load_word = dm_read;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      ready_reg <= 1'b1;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      flag_reg  <= 1'b0;
      rdata_reg <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      width_reg <= 2'd0;
      sign_reg  <= 1'b0;
      off_reg   <= 2'd0;
      wdata_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      flag_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            width_reg <= width;
            sign_reg  <= sign_ext;
            off_reg   <= byte_addr[1:0];
            wdata_reg <= wdata[15:0];
            ready_reg <= 1'b0;
            if (reject) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
              err_reg   <= 1'b1;
            end else begin
              addr_reg <= byte_addr[addr+1:2];
              if (!we) begin
                state_reg <= LOAD;
              end else if (width == 2'd2) begin
                state_reg <= WRITE;
                data_reg  <= wdata;
                flag_reg  <= 1'b1;
              end else begin
                state_reg <= MERGE;
              end
            end
          end
        end
        LOAD: begin
          rdata_reg <= load_word;
          done_reg  <= 1'b1;
          state_reg <= DONE;
        end
        MERGE: begin
          data_reg  <= merged_word;
          flag_reg  <= 1'b1;
          state_reg <= WRITE;
        end
        WRITE: begin
          done_reg  <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Reset must squash a write already presented to the memory in the same cycle.
  assign dm_flag    = {1'b0, flag_reg & ~reset};
  assign ready      = ready_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign rdata      = rdata_reg;
  assign dm_address = addr_reg;
  assign dm_data    = data_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level reference memory, queued expectations, done-driven monitor.
module tb_load_store_unit;

  localparam int BITS   = 32;
  localparam int ADDR   = 20;
  localparam int SIZE   = 100;
  localparam int MWORDS = 256;

  logic            clock = 1'b0;
  logic            reset;
  logic            req;
  logic            we;
  logic [1:0]      width;
  logic            sign_ext;
  logic [ADDR+1:0] byte_addr;
  logic [BITS-1:0] wdata;
  logic            ready;
  logic            done;
  logic            err;
  logic [BITS-1:0] rdata;
  logic [1:0]      dm_flag;
  logic [ADDR-1:0] dm_address;
  logic [BITS-1:0] dm_data;
  logic [BITS-1:0] dm_read;

  load_store_unit #(.bits(BITS), .addr(ADDR), .size(SIZE)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .width(width),
    .sign_ext(sign_ext), .byte_addr(byte_addr), .wdata(wdata),
    .ready(ready), .done(done), .err(err), .rdata(rdata),
    .dm_flag(dm_flag), .dm_address(dm_address), .dm_data(dm_data),
    .dm_read(dm_read)
  );

  always #5 clock = ~clock;

  // Data memory seen by the DUT
  logic [31:0]     mem [MWORDS];
  int              wr_cnt = 0;
  logic [ADDR-1:0] last_waddr;
  assign dm_read = mem[dm_address[7:0]];
  always @(posedge clock) begin
    if (dm_flag == 2'd1) begin
      mem[dm_address[7:0]] <= dm_data;
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= dm_address;
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: memory as a flat byte array
  logic [7:0]  mb [MWORDS*4];
  logic [31:0] m_rdata;

  typedef struct {
    logic            err;
    logic [31:0]     rdata;
    int              lat;
    int              writes;
    logic [ADDR-1:0] waddr;
    int              acc_cyc;
    int              wr_base;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pops one expectation
  always @(negedge clock) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no pending request (t=%0t)", $time);
      end else begin
        mon_e = q.pop_front();
        check("err", 32'(err), 32'(mon_e.err));
        check("rdata", rdata, mon_e.rdata);
        check("latency", cyc - mon_e.acc_cyc + 1, mon_e.lat);
        check("write_count", wr_cnt - mon_e.wr_base, mon_e.writes);
        if (mon_e.writes == 1) check("write_addr", 32'(last_waddr), 32'(mon_e.waddr));
        $display("txn done: err=%0d rdata=%h lat=%0d writes=%0d", err, rdata,
                 cyc - mon_e.acc_cyc + 1, wr_cnt - mon_e.wr_base);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clock);
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got ready=%b want 1 within 20 cycles", ready);
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] wd, input logic s,
                       input int a, input logic [31:0] d, input bit poke);
    exp_t        e;
    int          n;
    logic [31:0] val;
    wait_ready();
    n = 1 << wd;
    e.err = (wd == 2'd3) || (wd == 2'd1 && (a % 2) != 0) || (wd == 2'd2 && (a % 4) != 0);
`ifdef LSU_BOUND_CHECK_EN
    if (a / 4 >= SIZE) e.err = 1'b1;
`endif
    e.writes = 0;
    e.waddr  = '0;
    if (e.err) begin
      e.lat = 1;
    end else if (!w) begin
      val = '0;
      for (int i = 0; i < n; i++) val[8*i +: 8] = mb[a + i];
      if (s && n < 4 && val[8*n-1]) for (int i = 8*n; i < 32; i++) val[i] = 1'b1;
      m_rdata = val;
      e.lat = 2;
    end else begin
      for (int i = 0; i < n; i++) mb[a + i] = d[8*i +: 8];
      e.writes = 1;
      e.waddr  = ADDR'(a / 4);
      e.lat    = (wd == 2'd2) ? 2 : 3;
    end
    e.rdata   = m_rdata;
    e.acc_cyc = cyc + 1;
    e.wr_base = wr_cnt;
    q.push_back(e);
    req = 1'b1; we = w; width = wd; sign_ext = s; byte_addr = (ADDR+2)'(a); wdata = d;
    @(negedge clock);
    if (poke) begin
      // busy-time request: must be ignored
      we = 1'b1; width = 2'd2; byte_addr = (ADDR+2)'($urandom_range(0, 255) * 4); wdata = $urandom;
      @(negedge clock);
    end
    req = 1'b0;
  endtask

  task automatic reset_in_merge();
    int          base;
    logic [31:0] saved;
    wait_ready();
    base  = wr_cnt;
    saved = mem[3];
    req = 1'b1; we = 1'b1; width = 2'd0; sign_ext = 1'b0; byte_addr = (ADDR+2)'(13); wdata = 32'h000000A5;
    @(negedge clock);
    req = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_rdata = '0;
    check("rst_merge_ready", 32'(ready), 32'd1);
    check("rst_merge_rdata", rdata, 32'd0);
    repeat (3) @(negedge clock);
    check("rst_merge_writes", wr_cnt - base, 0);
    check("rst_merge_mem", mem[3], saved);
    $display("txn reset-in-merge: writes=%0d mem3=%h", wr_cnt - base, mem[3]);
  endtask

  task automatic reset_in_write();
    int          base;
    logic [31:0] saved;
    wait_ready();
    base  = wr_cnt;
    saved = mem[4];
    req = 1'b1; we = 1'b1; width = 2'd2; sign_ext = 1'b0; byte_addr = (ADDR+2)'(16); wdata = 32'h0BADF00D;
    @(negedge clock);
    req = 1'b0;
    check("rst_write_flag_before", 32'(dm_flag), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_write_flag_forced", 32'(dm_flag), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    m_rdata = '0;
    repeat (2) @(negedge clock);
    check("rst_write_writes", wr_cnt - base, 0);
    check("rst_write_mem", mem[4], saved);
    $display("txn reset-in-write: writes=%0d mem4=%h", wr_cnt - base, mem[4]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [1:0]  wd;
    int          r;
    int          a;
    reset = 1'b1; req = 1'b0; we = 1'b0; width = 2'd0; sign_ext = 1'b0;
    byte_addr = '0; wdata = '0; m_rdata = '0;
    for (int i = 0; i < MWORDS; i++) begin
      v = $urandom;
      mem[i] <= v;
      for (int k = 0; k < 4; k++) mb[4*i + k] = v[8*k +: 8];
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_dm_flag", 32'(dm_flag), 32'd0);
    check("reset_dm_address", 32'(dm_address), 32'd0);
    check("reset_dm_data", dm_data, 32'd0);

    // Directed sequence
    issue(1'b1, 2'd2, 1'b0, 8,  32'hDEADBEEF, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 8,  32'h0,        1'b1);
    issue(1'b1, 2'd0, 1'b0, 9,  32'h12345655, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 11, 32'h0,        1'b0);
    issue(1'b0, 2'd1, 1'b0, 10, 32'h0,        1'b0);
    issue(1'b0, 2'd1, 1'b1, 8,  32'h0,        1'b1);
    wait_ready();
    check("tp_shalf_literal", rdata, 32'h000055EF);
    check("tp_mem2_literal", mem[2], 32'hDEAD55EF);
    issue(1'b1, 2'd1, 1'b0, 5,  32'h0000CAFE, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 6,  32'h0,        1'b0);
    issue(1'b1, 2'd3, 1'b0, 12, 32'h11223344, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 400, 32'hA5A55A5A, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 400, 32'h0,        1'b0);
    reset_in_merge();
    reset_in_write();

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      wd = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a = $urandom_range(0, MWORDS*4 - 1);
      if (wd != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((1 << wd) - 1);
      issue(1'($urandom_range(0, 1)), wd, 1'($urandom_range(0, 1)), a, $urandom,
            ($urandom_range(0, 3) == 0));
    end

    wait_ready();
    repeat (4) @(negedge clock);
    check("queue_drained", q.size(), 0);
    for (int i = 0; i < MWORDS; i++)
      check("final_mem", mem[i], {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
